banked_main_mem: RTL and testbench

BANKED_MAIN_MEM -- requirements
Module: banked_main_mem

---
 rtl/banked_main_mem_pkg.sv | 20 ++
 rtl/banked_main_mem_mem_bank.sv | 60 ++++++
 rtl/banked_main_mem.sv | 61 ++++++
 tb/tb_banked_main_mem.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/banked_main_mem_pkg.sv
// Shared sizing and bank request payload for the four-bank interleaved main memory.
package banked_main_mem_pkg;

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned BANK_OCC  = 4;
    localparam int unsigned ROW_W     = 13;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W     = $clog2(BANK_OCC);
    localparam int unsigned ROWS      = 1 << ROW_W;

    typedef struct packed {
        logic              we;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] wdata;
    } bank_req_t;

endpackage

// File: rtl/banked_main_mem_mem_bank.sv
// One memory bank: word storage, occupancy counter and fixed-latency read-return pipe.
module mem_bank
    import banked_main_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld_i,
    input  bank_req_t         req_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q  [ROWS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pipe_q [RD_LAT];
    logic [DATA_W-1:0] pipe_d [RD_LAT];

    // Occupancy countdown and read pipe; idle stages carry zero so the top can OR banks.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_d[i] = '0;
        end
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (req_vld_i) begin
            cnt_d = CNT_W'(BANK_OCC - 1);
        end
        pipe_d[0] = (req_vld_i && !req_i.we) ? mem_q[req_i.row] : '0;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (req_vld_i && req_i.we) begin
            mem_q[req_i.row] <= req_i.wdata;
        end
    end

    assign busy_o  = (cnt_q != '0);
    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank interleaved main memory: bank decode, stall/err and return OR.
// Define MEM_UNALIGNED_ERR_EN to flag odd byte addresses as errors.
module banked_main_mem
    import banked_main_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 stall,
    output logic                 err
);

    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic              req;
    logic              accept;
    bank_req_t         bank_req;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    assign bank = addr[BANK_W:1];
    assign row  = addr[ADDR_W-1:BANK_W+1];
    assign req  = wr ^ rd;

`ifdef MEM_UNALIGNED_ERR_EN
    assign err = !rst && ((wr && rd) || ((wr || rd) && addr[0]));
`else
    logic unused_byte_bit;
    assign unused_byte_bit = addr[0];
    assign err = !rst && wr && rd;
`endif

    // Requests during reset are ignored rather than refused.
    assign stall  = !rst && req && !err && busy[bank];
    assign accept = !rst && req && !err && !busy[bank];

    assign bank_req = '{we: wr, row: row, wdata: data_in};

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        mem_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .req_vld_i (accept && (bank == BANK_W'(b))),
            .req_i     (bank_req),
            .busy_o    (busy[b]),
            .rdata_o   (bank_rdata[b])
        );
    end

    always_comb begin
        data_out = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            data_out = data_out | bank_rdata[b];
        end
    end

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed bench for banked_main_mem with a cycle-stamped read-return scoreboard.
module tb_banked_main_mem;

    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [15:0] addr, data_in;
    logic [15:0] data_out;
    logic [3:0]  busy;
    logic        stall, err;

`ifdef MEM_UNALIGNED_ERR_EN
    localparam bit UNAL_ERR = 1'b1;
`else
    localparam bit UNAL_ERR = 1'b0;
`endif

    banked_main_mem dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .busy     (busy),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          cyc, n_cmp, n_bad;
    bit          chk_en;
    int          exp_cyc [$];
    logic [15:0] exp_dat [$];
    logic [15:0] model [int];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Finish the current cycle: check data_out against the scoreboard, advance one edge.
    task automatic tick();
        logic [15:0] d;
        @(negedge clk);
        if (chk_en) begin
            if (exp_cyc.size() != 0 && exp_cyc[0] == cyc) begin
                d = exp_dat.pop_front();
                void'(exp_cyc.pop_front());
                check($sformatf("dout@%0d", cyc), data_out, d);
            end else begin
                check($sformatf("dout_zero@%0d", cyc), data_out, 16'h0000);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_busy(input logic [3:0] e);
        check($sformatf("busy@%0d", cyc), 16'(busy), 16'(e));
    endtask

    task automatic req(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d,
                       input logic exp_stall, input logic exp_err);
        wr = w; rd = r; addr = a; data_in = d;
        #1;
        check($sformatf("stall@%0d", cyc), 16'(stall), 16'(exp_stall));
        check($sformatf("err@%0d", cyc), 16'(err), 16'(exp_err));
        if ((w ^ r) && !exp_stall && !exp_err) begin
            if (w) begin
                model[int'(a[15:1])] = d;
            end else begin
                exp_cyc.push_back(cyc + 2);
                exp_dat.push_back(model[int'(a[15:1])]);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        cyc = 0; n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;

        // Reset state, then preload one word per bank.
        chk_busy(4'b0000);
        req(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b0);
        chk_busy(4'b0001); req(1'b1, 1'b0, 16'h0002, 16'h2222, 1'b0, 1'b0);
        chk_busy(4'b0011); req(1'b1, 1'b0, 16'h0004, 16'h3333, 1'b0, 1'b0);
        chk_busy(4'b0111); req(1'b1, 1'b0, 16'h0006, 16'h4444, 1'b0, 1'b0);
        chk_busy(4'b1110); req(1'b1, 1'b0, 16'h0008, 16'h5555, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0000, 16'hDEAD, 1'b1, 1'b0);
        idle(2);
        req(1'b1, 1'b0, 16'h0020, 16'h1234, 1'b0, 1'b0);
        idle(4);

        // Write then read the same word four cycles later.
        req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0000);
        req(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0);
        idle(4);

        // Back-to-back reads across all four banks.
        chk_busy(4'b0000); req(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk_busy(4'b0001); req(1'b0, 1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0);
        chk_busy(4'b0011); req(1'b0, 1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0);
        chk_busy(4'b0111); req(1'b0, 1'b1, 16'h0006, 16'h0000, 1'b0, 1'b0);
        chk_busy(4'b1110); idle(1);
        chk_busy(4'b1100); idle(1);
        chk_busy(4'b1000); idle(1);
        chk_busy(4'b0000); idle(1);

        // Same-bank conflict: stalled at t+1 and t+3, accepted at t+4.
        req(1'b0, 1'b1, 16'h0008, 16'h0000, 1'b0, 1'b0);
        chk_busy(4'b0001); req(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0001); req(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
        chk_busy(4'b0000); req(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        idle(4);

        // Simultaneous wr&rd is an error: no stall, no write, no occupancy.
        req(1'b1, 1'b0, 16'h0100, 16'hA5A5, 1'b0, 1'b0);
        req(1'b1, 1'b1, 16'h0100, 16'hFFFF, 1'b0, 1'b1);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0001); idle(1);
        chk_busy(4'b0000);
        req(1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
        req(1'b1, 1'b1, 16'h0002, 16'hFFFF, 1'b0, 1'b1);
        chk_busy(4'b0001); idle(3);

        // Reset discards a pending read, ignores its own-cycle request, keeps storage.
        req(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1; rd = 1'b1; addr = 16'h0002;
        #1;
        while (exp_cyc.size() != 0 && exp_cyc[exp_cyc.size()-1] > cyc) begin
            void'(exp_cyc.pop_back());
            void'(exp_dat.pop_back());
        end
        tick();
        rst = 1'b0;
        chk_busy(4'b0000);
        req(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0);
        idle(4);

        // Odd byte address: error when enabled, otherwise the containing word.
        req(1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, UNAL_ERR);
        idle(4);

        check("scoreboard_drained", 16'(exp_cyc.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
